// File: rtl/cellrv32_cpu_cp_fpu_i2f.sv
// Integer to binary32 converter (FCVT.S.W / FCVT.S.WU) for the FPU co-processor.
// Multi-cycle: normalization shifts one bit per cycle, then a single rounding step.
module cellrv32_cpu_cp_fpu_i2f #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic [2:0]      rmode_i,
  input  logic            funct_i,
  input  logic [XLEN-1:0] int_i,
  output logic [31:0]     result_o,
  output logic [4:0]      flags_o,
  output logic            done_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREPARE   = 3'd1,
    S_NORMALIZE = 3'd2,
    S_ROUND     = 3'd3,
    S_FINALIZE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [2:0]      mode;
  logic            sign;
  logic [XLEN-1:0] mag;
  logic [7:0]      exp;
  logic [22:0]     mant;
  logic            zero;
  logic            nx;

  logic            load;
  logic            finish;
  logic            in_sign;
  logic [XLEN-1:0] in_mag;

  logic [22:0]     mant_raw;
  logic            g_bit, r_bit, s_bit, inexact, inc;
  logic [23:0]     mant_sum;
  logic [22:0]     mant_rnd;
  logic [7:0]      exp_rnd;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:      state_nxt = start_i ? S_PREPARE : S_IDLE;
      S_PREPARE:   state_nxt = (mag == '0) ? S_FINALIZE : S_NORMALIZE;
      S_NORMALIZE: state_nxt = mag[XLEN-1] ? S_ROUND : S_NORMALIZE;
      S_ROUND:     state_nxt = S_FINALIZE;
      S_FINALIZE:  state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State-decoded control strobes
  always_comb begin
    load   = (state == S_IDLE) && start_i;
    finish = (state == S_FINALIZE);
  end

  // Operand sign/magnitude extraction at start
  always_comb begin
    in_sign = ~funct_i & int_i[XLEN-1];
    in_mag  = in_sign ? ('0 - int_i) : int_i;
  end

  // Rounding decision on the normalized magnitude (hidden bit is mag[31])
  always_comb begin
    mant_raw = mag[30:8];
    g_bit    = mag[7];
    r_bit    = mag[6];
    s_bit    = |mag[5:0];
    inexact  = g_bit | r_bit | s_bit;
    case (mode)
      3'b000:  inc = g_bit & (r_bit | s_bit | mant_raw[0]);
      3'b010:  inc = sign & inexact;
      3'b011:  inc = ~sign & inexact;
      3'b100:  inc = g_bit;
      default: inc = 1'b0;
    endcase
    mant_sum = {1'b0, mant_raw} + 24'd1;
    mant_rnd = mant_raw;
    exp_rnd  = exp;
    if (inc) begin
      // a carry out leaves sum[22:0] all zero, which is the required mantissa
      mant_rnd = mant_sum[22:0];
      exp_rnd  = exp + {7'd0, mant_sum[23]};
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode     <= '0;
      sign     <= 1'b0;
      mag      <= '0;
      exp      <= '0;
      mant     <= '0;
      zero     <= 1'b0;
      nx       <= 1'b0;
      result_o <= '0;
      flags_o  <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (load) begin
        mode <= rmode_i;
        sign <= in_sign;
        mag  <= in_mag;
        zero <= 1'b0;
        nx   <= 1'b0;
      end
      case (state)
        S_PREPARE: begin
          if (mag == '0) zero <= 1'b1;
          else           exp  <= 8'd158;
        end
        S_NORMALIZE: begin
          if (!mag[XLEN-1]) begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
          end
        end
        S_ROUND: begin
          mant <= mant_rnd;
          exp  <= exp_rnd;
          nx   <= inexact;
        end
        default: ;
      endcase
      if (finish) begin
        result_o <= zero ? 32'h0 : {sign, exp, mant};
        flags_o  <= {4'b0000, nx & ~zero};
        done_o   <= 1'b1;
      end
    end
  end

endmodule
